// File: rtl/fixed_point_divider_pkg.sv
// Shared types and helpers for the iterative fixed-point divider.
package div_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Largest supported fractional extension of the dividend
    localparam int FRAC_MAX = 32;

    // Number of restoring steps: integer bits, fractional bits, plus one round bit
    function automatic int iter_count(input int num_w, input int frac_bits);
        return num_w + frac_bits + 1;
    endfunction

    // All-ones pattern of the given width (widths up to 64)
    function automatic logic [63:0] all_ones(input int w);
        if (w >= 64) begin
            return '1;
        end
        return (64'd1 << w) - 64'd1;
    endfunction

endpackage

// File: rtl/fixed_point_divider_if.sv
// Start/ack coprocessor interface of the fixed-point divider.
interface fixed_point_divider_if #(
    parameter int NUM_W  = 16,
    parameter int DEN_W  = 16,
    parameter int QUOT_W = 16
);
    logic              start;
    logic              round;
    logic [NUM_W-1:0]  dividend;
    logic [DEN_W-1:0]  divisor;
    logic [QUOT_W-1:0] quotient;
    logic              ovf;
    logic              div_zero;
    logic              busy;
    logic              ack;

    modport master (
        output start, round, dividend, divisor,
        input  quotient, ovf, div_zero, busy, ack
    );

    modport slave (
        input  start, round, dividend, divisor,
        output quotient, ovf, div_zero, busy, ack
    );
endinterface

// File: rtl/fixed_point_divider_step.sv
// One combinational restoring-division step.
module div_step #(
    parameter int DEN_W = 16
) (
    input  logic [DEN_W-1:0] rem,
    input  logic             bit_in,
    input  logic [DEN_W-1:0] divisor,
    output logic [DEN_W-1:0] rem_next,
    output logic             q_bit
);
    logic [DEN_W:0] trial;
    logic [DEN_W:0] diff;

    // Shift the next numerator bit in and subtract when the divisor fits;
    // the remainder always stays below the divisor, so DEN_W bits hold it.
    always_comb begin
        trial    = {rem, bit_in};
        diff     = trial - {1'b0, divisor};
        q_bit    = (trial >= {1'b0, divisor});
        rem_next = q_bit ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
    end
endmodule

// File: rtl/fixed_point_divider.sv
// Iterative restoring divider: quotient = floor(dividend * 2^FRAC_BITS / divisor),
// with optional round-half-up and saturation to QUOT_W bits (QUOT_W <= 64).
module fixed_point_divider
    import div_pkg::*;
#(
    parameter int NUM_W     = 16,
    parameter int DEN_W     = 16,
    parameter int QUOT_W    = 16,
    parameter int FRAC_BITS = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    fixed_point_divider_if.slave bus
);
    localparam int ITER  = iter_count(NUM_W, FRAC_BITS);
    localparam int CNT_W = $clog2(ITER + 1);
    // Rounded-result width: wide enough for the carry and for the saturation test
    localparam int WW    = (ITER > QUOT_W) ? ITER : QUOT_W + 1;

    state_t           state;
    logic [ITER-1:0]  num_sr;
    logic [ITER-1:0]  q_acc;
    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den;
    logic             rnd;
    logic [CNT_W-1:0] cnt;

    logic [DEN_W-1:0] rem_next;
    logic             q_bit;
    logic [WW-1:0]    q_round;
    logic             sat;

    div_step #(.DEN_W(DEN_W)) u_step (
        .rem      (rem),
        .bit_in   (num_sr[ITER-1]),
        .divisor  (den),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Final result: raw quotient plus round bit when rounding, then overflow test
    always_comb begin
        q_round = WW'(q_acc[ITER-1:1]) + WW'(rnd & q_acc[0]);
        sat     = |(q_round >> QUOT_W);
    end

    // Controller and datapath; all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            num_sr       <= '0;
            q_acc        <= '0;
            rem          <= '0;
            den          <= '0;
            rnd          <= 1'b0;
            cnt          <= '0;
            bus.quotient <= '0;
            bus.ovf      <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.busy     <= 1'b0;
            bus.ack      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        den          <= bus.divisor;
                        rnd          <= bus.round;
                        num_sr       <= {bus.dividend, {(FRAC_BITS + 1){1'b0}}};
                        q_acc        <= '0;
                        rem          <= '0;
                        bus.ovf      <= 1'b0;
                        bus.quotient <= '0;
                        if (bus.divisor == '0) begin
                            bus.quotient <= QUOT_W'(all_ones(QUOT_W));
                            bus.div_zero <= 1'b1;
                            bus.ack      <= 1'b1;
                            state        <= DONE;
                        end else begin
                            bus.div_zero <= 1'b0;
                            cnt          <= CNT_W'(ITER);
                            bus.busy     <= 1'b1;
                            state        <= RUN;
                        end
                    end
                end
                RUN: begin
                    // ITER steps, then one cycle to form the result
                    if (cnt == '0) begin
                        bus.busy <= 1'b0;
                        bus.ack  <= 1'b1;
                        state    <= DONE;
                        if (sat) begin
                            bus.quotient <= QUOT_W'(all_ones(QUOT_W));
                            bus.ovf      <= 1'b1;
                        end else begin
                            bus.quotient <= q_round[QUOT_W-1:0];
                        end
                    end else begin
                        rem    <= rem_next;
                        q_acc  <= {q_acc[ITER-2:0], q_bit};
                        num_sr <= {num_sr[ITER-2:0], 1'b0};
                        cnt    <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    // Hold the result until start drops, so a held start cannot relaunch
                    if (!bus.start) begin
                        bus.ack <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fixed_point_divider.sv
// Scoreboard bench for fixed_point_divider: a default Q1.15 instance and a 16/8->24 instance.
module tb_fixed_point_divider;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fixed_point_divider_if #(.NUM_W(16), .DEN_W(16), .QUOT_W(16)) bus_a ();
    fixed_point_divider_if #(.NUM_W(16), .DEN_W(8),  .QUOT_W(24)) bus_b ();

    fixed_point_divider #(.NUM_W(16), .DEN_W(16), .QUOT_W(16), .FRAC_BITS(15)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    fixed_point_divider #(.NUM_W(16), .DEN_W(8), .QUOT_W(24), .FRAC_BITS(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        logic [23:0] q;
        logic        ovf;
        logic        dz;
    } exp_t;

    exp_t exp_a[$];
    exp_t exp_b[$];

    int n_pass  = 0;
    int n_total = 0;
    int excl_viol = 0;
    logic ack_prev_a = 1'b0;
    logic ack_prev_b = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    // Monitor: on each rising ack pop the oldest expectation and compare
    always @(negedge clk) begin
        exp_t e;
        if (bus_a.ack && !ack_prev_a) begin
            if (exp_a.size() == 0) begin
                check("a_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_a.pop_front();
                check("a_quotient", {16'd0, bus_a.quotient}, {8'd0, e.q});
                check("a_ovf", {31'd0, bus_a.ovf}, {31'd0, e.ovf});
                check("a_divzero", {31'd0, bus_a.div_zero}, {31'd0, e.dz});
            end
        end
        if (bus_b.ack && !ack_prev_b) begin
            if (exp_b.size() == 0) begin
                check("b_unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_b.pop_front();
                check("b_quotient", {8'd0, bus_b.quotient}, {8'd0, e.q});
                check("b_ovf", {31'd0, bus_b.ovf}, {31'd0, e.ovf});
                check("b_divzero", {31'd0, bus_b.div_zero}, {31'd0, e.dz});
            end
        end
        if ((bus_a.ack && bus_a.busy) || (bus_b.ack && bus_b.busy)) begin
            excl_viol++;
        end
        ack_prev_a = bus_a.ack;
        ack_prev_b = bus_b.ack;
    end

    function automatic logic ack_of(input bit sel);
        return sel ? bus_b.ack : bus_a.ack;
    endfunction

    function automatic logic [23:0] quot_of(input bit sel);
        return sel ? bus_b.quotient : {8'd0, bus_a.quotient};
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus_b.start = v;
        else     bus_a.start = v;
    endtask

    // Launch one operation, push its expectation, and measure edges from accept to ack.
    // hold keeps start high through completion; pulse_at >= 0 pulses start during RUN.
    task automatic run_op(input bit sel, input logic [15:0] dvd, input logic [15:0] dvs,
                          input logic rnd, input logic [23:0] eq, input logic eo,
                          input logic ez, input int elat, input bit hold, input int pulse_at);
        exp_t e;
        int c;
        e.q = eq; e.ovf = eo; e.dz = ez;
        @(negedge clk);
        if (sel) begin
            bus_b.dividend = dvd; bus_b.divisor = dvs[7:0]; bus_b.round = rnd;
            exp_b.push_back(e);
        end else begin
            bus_a.dividend = dvd; bus_a.divisor = dvs; bus_a.round = rnd;
            exp_a.push_back(e);
        end
        set_start(sel, 1'b1);
        @(posedge clk);
        c = 0;
        #1;
        while (!ack_of(sel) && c < 100) begin
            @(negedge clk);
            if (c == 0 && !hold) set_start(sel, 1'b0);
            if (c == pulse_at) begin
                bus_a.dividend = 16'd1; bus_a.divisor = 16'd3;
                set_start(sel, 1'b1);
            end
            if (pulse_at >= 0 && c == pulse_at + 1) set_start(sel, 1'b0);
            @(posedge clk);
            c++;
            #1;
        end
        check("latency", c, elat);
        if (hold) begin
            repeat (5) begin
                @(posedge clk);
                #1;
                check("hold_ack", {31'd0, ack_of(sel)}, 32'd1);
                check("hold_quotient", {8'd0, quot_of(sel)}, {8'd0, eq});
            end
        end
        @(negedge clk);
        set_start(sel, 1'b0);
        @(posedge clk);
        #1;
        check("ack_release", {31'd0, ack_of(sel)}, 32'd0);
    endtask

    initial begin
        bus_a.start = 1'b0; bus_a.round = 1'b0; bus_a.dividend = '0; bus_a.divisor = '0;
        bus_b.start = 1'b0; bus_b.round = 1'b0; bus_b.dividend = '0; bus_b.divisor = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_quotient", {16'd0, bus_a.quotient}, 32'd0);
        check("rst_a_flags", {27'd0, bus_a.ovf, bus_a.div_zero, bus_a.busy, bus_a.ack, 1'b0}, 32'd0);
        check("rst_b_quotient", {8'd0, bus_b.quotient}, 32'd0);
        check("rst_b_flags", {28'd0, bus_b.ovf, bus_b.div_zero, bus_b.busy, bus_b.ack}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Default Q1.15 instance
        run_op(1'b0, 16'd1, 16'd4,  1'b0, 24'h002000, 1'b0, 1'b0, 33, 1'b0, -1);
        run_op(1'b0, 16'd1, 16'd36, 1'b0, 24'h00038E, 1'b0, 1'b0, 33, 1'b0, -1);
        run_op(1'b0, 16'd1, 16'd3,  1'b0, 24'h002AAA, 1'b0, 1'b0, 33, 1'b0, -1);
        run_op(1'b0, 16'd1, 16'd3,  1'b1, 24'h002AAB, 1'b0, 1'b0, 33, 1'b0, -1);
        run_op(1'b0, 16'd5, 16'd0,  1'b0, 24'h00FFFF, 1'b0, 1'b1, 0,  1'b0, -1);
        run_op(1'b0, 16'd2, 16'd1,  1'b0, 24'h00FFFF, 1'b1, 1'b0, 33, 1'b0, -1);
        run_op(1'b0, 16'd1, 16'd1,  1'b0, 24'h008000, 1'b0, 1'b0, 33, 1'b0, -1);
        run_op(1'b0, 16'd0, 16'd5,  1'b0, 24'h000000, 1'b0, 1'b0, 33, 1'b0, -1);

        // 16/8 -> 24-bit instance (8 fractional bits: 26-edge latency)
        run_op(1'b1, 16'd1000,  16'd7, 1'b0, 24'h008EDB, 1'b0, 1'b0, 26, 1'b0, -1);
        run_op(1'b1, 16'hFFFF,  16'd1, 1'b0, 24'hFFFF00, 1'b0, 1'b0, 26, 1'b0, -1);
        run_op(1'b1, 16'h1234,  16'd0, 1'b0, 24'hFFFFFF, 1'b0, 1'b1, 0,  1'b0, -1);

        // Handshake: held start, then start pulsed during RUN (ignored)
        run_op(1'b0, 16'd1, 16'd3, 1'b1, 24'h002AAB, 1'b0, 1'b0, 33, 1'b1, -1);
        run_op(1'b0, 16'd1, 16'd4, 1'b0, 24'h002000, 1'b0, 1'b0, 33, 1'b0, 5);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        bus_a.dividend = 16'd1; bus_a.divisor = 16'd4; bus_a.round = 1'b0;
        bus_a.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("run_busy", {31'd0, bus_a.busy}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_quotient", {16'd0, bus_a.quotient}, 32'd0);
        check("async_rst_flags", {28'd0, bus_a.ovf, bus_a.div_zero, bus_a.busy, bus_a.ack}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(1'b0, 16'd1, 16'd4, 1'b0, 24'h002000, 1'b0, 1'b0, 33, 1'b0, -1);

        repeat (3) @(posedge clk);
        check("scoreboard_a_empty", exp_a.size(), 32'd0);
        check("scoreboard_b_empty", exp_b.size(), 32'd0);
        check("busy_ack_exclusive", excl_viol, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fixed_point_divider.md
Name: fixed_point_divider

Overview:
Parametrised iterative restoring divider that computes Quotient = floor(Dividend·2^FRAC_BITS / Divisor) with optional round-half-up and saturation.
- Successor to the software 1/x routine and the 16/8 division routine: one engine serves both, e.g. Q1.15 reciprocal (NUM_W=16, FRAC_BITS=15, QUOT_W=16) and 16/8→24-bit (DEN_W=8, FRAC_BITS=8, QUOT_W=24).
- Sits beside the CPU datapath as a start/ack coprocessor; also usable as a standalone test target.

Parameters:
NUM_W, 16, dividend width (unsigned integer)
DEN_W, 16, divisor width (unsigned integer)
QUOT_W, 16, output quotient width
FRAC_BITS, 15, fractional bits appended to dividend (0..32)

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  launch request (level, sampled in IDLE)
Round  in  1  1 = round half-LSB upward, 0 = truncate; sampled with Start
Dividend  in  NUM_W  numerator, sampled with Start
Divisor  in  DEN_W  denominator, sampled with Start
Quotient  out  QUOT_W  result, valid while Ack=1
Ovf  out  1  result saturated due to overflow (incl. rounding carry-out)
DivZero  out  1  Divisor was 0
Busy  out  1  high in RUN
Ack  out  1  result valid / operation complete

Behaviour:
- Reset (Reset=0, any time, including mid-RUN): state=IDLE; Quotient=0, Ovf=0, DivZero=0, Busy=0, Ack=0; iteration counter and remainder cleared. Operation in flight is discarded.
- ITER = NUM_W+FRAC_BITS+1. The extra iteration yields the round bit.
- States:
  - IDLE: on Start=1, latch Dividend, Divisor and Round, then clear flags. If Divisor==0, go to DONE with Quotient=all ones and DivZero=1 (Ack 1 cycle after the accepting edge). Otherwise go to RUN with counter=ITER.
  - RUN: one restoring step per cycle. Remainder (DEN_W+1 bits) = {rem, next numerator bit}; if ≥ Divisor, subtract and shift in 1, else shift in 0. Numerator bits are Dividend MSB-first, then FRAC_BITS+1 zeros. After ITER steps go to DONE. Start is ignored during RUN.
  - DONE: Ack=1. Quotient, Ovf and DivZero are held stable. Exit to IDLE only when Start=0, so a Start held high across completion does not relaunch. A new operation requires Start to drop and rise again.
- Latency: Ack is high ITER+1 rising edges after the edge that accepts Start. For the defaults that is 33 cycles.
- Result formation at the RUN→DONE transition:
  - Raw integer q has NUM_W+FRAC_BITS bits plus round bit r.
  - If Round=1: q' = q + r, else q' = q.
  - If q' ≥ 2^QUOT_W (any upper bit set, or carry out of the add): Quotient = all ones, Ovf = 1.
  - Otherwise Quotient = q'[QUOT_W-1:0].
- Busy=1 exactly in RUN; Ack=1 exactly in DONE; never both.
- Dividend=0 with Divisor≠0 runs full latency and returns 0.

Decomposition:
- Shared package div_pkg holds:
  - state encoding constants IDLE/RUN/DONE (2 bits)
  - function iter_count(NUM_W, FRAC_BITS)
  - saturation constant helper (all-ones of a given width)
- One natural sub-module, div_step: combinational single restoring step. Inputs: remainder, incoming bit, divisor. Outputs: next remainder, quotient bit. Parametrised by DEN_W and instantiated once in the iterative datapath.

Test Plan:
1. Defaults, Dividend=1, Divisor=4, Round=0 → Quotient=0x2000, Ovf=0, DivZero=0; Ack rises exactly 33 cycles after the Start-accepting edge.
2. Defaults, Dividend=1, Divisor=36 → 0x038E. Divisor=3, Round=0 → 0x2AAA. Divisor=3, Round=1 → 0x2AAB.
3. Defaults, Divisor=0 → Quotient=0xFFFF, DivZero=1, Ack one cycle after accept. Dividend=2, Divisor=1 → 0xFFFF, Ovf=1. Dividend=1, Divisor=1 → 0x8000, Ovf=0.
4. NUM_W=16, DEN_W=8, QUOT_W=24, FRAC_BITS=8: Dividend=1000, Divisor=7 → 0x008EDB. Dividend=0xFFFF, Divisor=1 → 0xFFFF00, Ovf=0.
5. Handshake: Start held high through completion → Ack stays 1, results stable, no relaunch. Start pulsed during RUN → ignored. Start dropped, then re-raised → new operation accepted.
6. Reset pulled low at RUN cycle 10 → all outputs 0 immediately (asynchronous). After release, a fresh Start with Divisor=4 returns 0x2000 with full latency.
